mdio_request_arbiter: RTL and testbench
=======================================

// Module: mdio_request_arbiter
// PURPOSE
//  Shares one EthernetMDIOTransceiver management port between NUM_REQ independent requesters (CPU APB bridge,
//  link-state poller, PHY init sequencer). Round-robin grant, one MDIO transaction in flight at a time, per-requester
//  one-cycle response pulse. A watchdog aborts any transaction that the transceiver never completes.
// PARAMETERS
//  NUM_REQ      4      number of requester ports (2..8)
//  SETTLE       2      cycles after issue before busy is sampled (>=1)
//  TIMEOUT      4095   cycles in WAIT before abort; also sets timer width $clog2(TIMEOUT+1)
// PORTS
//  clk            in   1           clock, shared with transceiver
//  rst            in   1           synchronous reset, active high
//  req_valid      in   NUM_REQ     requester i has a transaction pending; held until accepted
//  req_ready      out  NUM_REQ     one-hot accept; transaction i is accepted when req_valid[i] && req_ready[i]
//  req_write      in   NUM_REQ     1=write, 0=read, per requester
//  req_md_addr    in   5*NUM_REQ   PHY address, requester i at [5i+:5]
//  req_reg_addr   in   5*NUM_REQ   register address, requester i at [5i+:5]
//  req_wr_data    in   16*NUM_REQ  write data, requester i at [16i+:16]
//  resp_valid     out  NUM_REQ     one-hot, one-cycle completion pulse to the granted requester
//  resp_err       out  1           qualifies resp_valid: 1 = timed out
//  resp_data      out  16          read data (0 for writes and for errors); valid with resp_valid
//  phy_md_addr    out  5           to transceiver; held stable for whole transaction
//  phy_reg_addr   out  5           to transceiver; held stable for whole transaction
//  phy_wr_data    out  16          to transceiver; held stable for whole transaction
//  phy_reg_rd     out  1           one-cycle read strobe
//  phy_reg_wr     out  1           one-cycle write strobe
//  mgmt_busy      in   1           transceiver busy
//  phy_rd_data    in   16          transceiver read data, valid once busy drops after a read
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1 (so requester 0 wins first); timer 0; latches 0.
//  States: IDLE -> ISSUE -> SETTLE -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid and !mgmt_busy, pick first valid index scanning from ptr+1 upward with wrap; assert
//   req_ready[g] combinationally that cycle; on edge latch index, write flag, addresses, data; ptr <= g; -> ISSUE.
//   No req_ready while mgmt_busy=1 or outside IDLE.
//  ISSUE: exactly one cycle of phy_reg_wr (write) or phy_reg_rd (read); never both; -> SETTLE, counter = SETTLE.
//  SETTLE: count down SETTLE cycles, busy ignored (covers transceiver busy-rise latency); -> WAIT, timer=0.
//  WAIT: each cycle mgmt_busy=0 -> RESP with err=0, capture phy_rd_data (reads) on that edge; else timer+1;
//   timer reaching TIMEOUT -> RESP with err=1, resp_data=0.
//  RESP: one cycle resp_valid[idx]=1 with resp_err/resp_data; -> IDLE. Next grant earliest the cycle after RESP.
//  Turnaround: issue-to-resp = 1+SETTLE+(busy cycles)+1; back-to-back grants separated by >=1 IDLE cycle.
//  Fairness: requester holding valid continuously is granted within NUM_REQ transactions.
//  req_valid dropping before acceptance: permitted, no effect. Changing req_* of a non-granted port: no effect.
//  Request fields of granted port ignored after accept (latched copy drives the PHY bus).
//  phy_* address/data outputs hold last transaction values in IDLE (no glitch to 0 between ops).
//  Timeout does not reset the transceiver; next grant still waits for mgmt_busy=0 in IDLE.
//  rst mid-transaction: FSM to IDLE, no resp pulse, strobes deasserted same edge; in-flight MDIO frame is
//   the transceiver's responsibility.
// TESTING
//  Single read: req 1 valid, rd md=3 reg=2, model returns 0x796D after 40 busy cycles -> one phy_reg_rd pulse,
//   md/reg held 3/2, resp_valid=4'b0010, resp_data=0x796D, resp_err=0.
//  Write: req 0 wr md=1 reg=0 data=0x8000 -> one phy_reg_wr, phy_wr_data=0x8000 held, resp_data=0, resp_valid=4'b0001.
//  Round robin: all 4 valid continuously, 8 txns -> grant order 0,1,2,3,0,1,2,3; no requester waits >3 grants.
//  Busy at start: mgmt_busy=1 before request -> req_ready stays 0 until busy drops, then grant next cycle.
//  Timeout: TIMEOUT=16, busy stuck high -> resp_err=1, resp_data=0 exactly 1+SETTLE+16 cycles after issue.
//  Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0, no resp pulse, next request served from requester 0.

Source files
------------

// File: rtl/mdio_request_arbiter.sv
// mdio_request_arbiter: round-robin sharing of one MDIO management port
// between NUM_REQ requesters, one transaction in flight, with watchdog.
module mdio_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [5*NUM_REQ-1:0]  req_md_addr,
  input  logic [5*NUM_REQ-1:0]  req_reg_addr,
  input  logic [16*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic                  resp_err,
  output logic [15:0]           resp_data,
  output logic [4:0]            phy_md_addr,
  output logic [4:0]            phy_reg_addr,
  output logic [15:0]           phy_wr_data,
  output logic                  phy_reg_rd,
  output logic                  phy_reg_wr,
  input  logic                  mgmt_busy,
  input  logic [15:0]           phy_rd_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  logic            wr_q;
  logic [4:0]      md_q;
  logic [4:0]      reg_q;
  logic [15:0]     wd_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   timer_q;
  logic            rd_stb_q;
  logic            wr_stb_q;
  logic [NUM_REQ-1:0] rv_q;
  logic            rerr_q;
  logic [15:0]     rdata_q;

  logic [IW-1:0]   hi_idx_d;
  logic [IW-1:0]   lo_idx_d;
  logic            hi_fnd_d;
  logic            lo_fnd_d;
  logic [IW-1:0]   gnt_idx_d;
  logic            gnt_ok_d;
  logic            sel_wr_d;
  logic [4:0]      sel_md_d;
  logic [4:0]      sel_reg_d;
  logic [15:0]     sel_wd_d;

  // Rotating priority: lowest valid index above ptr, else lowest overall
  always_comb begin
    hi_idx_d = '0;
    lo_idx_d = '0;
    hi_fnd_d = 1'b0;
    lo_fnd_d = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx_d = IW'(i);
        lo_fnd_d = 1'b1;
        if (IW'(i) > ptr_q) begin
          hi_idx_d = IW'(i);
          hi_fnd_d = 1'b1;
        end
      end
    end
    gnt_idx_d = hi_fnd_d ? hi_idx_d : lo_idx_d;
    gnt_ok_d  = (state_q == S_IDLE) && !mgmt_busy && lo_fnd_d;
  end

  // Mux out the winning requester's fields and its one-hot accept
  always_comb begin
    sel_wr_d  = 1'b0;
    sel_md_d  = '0;
    sel_reg_d = '0;
    sel_wd_d  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_d == IW'(i)) begin
        sel_wr_d  = req_write[i];
        sel_md_d  = req_md_addr[5*i +: 5];
        sel_reg_d = req_reg_addr[5*i +: 5];
        sel_wd_d  = req_wr_data[16*i +: 16];
      end
    end
    if (gnt_ok_d) begin
      req_ready[gnt_idx_d] = 1'b1;
    end
  end

  // Transaction sequencer: grant, strobe, settle, watch busy, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NUM_REQ - 1);
      idx_q    <= '0;
      wr_q     <= 1'b0;
      md_q     <= '0;
      reg_q    <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      rv_q     <= '0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      rv_q     <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_ok_d) begin
            idx_q    <= gnt_idx_d;
            ptr_q    <= gnt_idx_d;
            wr_q     <= sel_wr_d;
            md_q     <= sel_md_d;
            reg_q    <= sel_reg_d;
            wd_q     <= sel_wd_d;
            wr_stb_q <= sel_wr_d;
            rd_stb_q <= !sel_wr_d;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CW'(SETTLE);
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q <= CW'(1)) begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (!mgmt_busy) begin
            rv_q[idx_q] <= 1'b1;
            rerr_q      <= 1'b0;
            rdata_q     <= wr_q ? 16'h0000 : phy_rd_data;
            state_q     <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rv_q[idx_q] <= 1'b1;
            rerr_q      <= 1'b1;
            rdata_q     <= 16'h0000;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RESP: begin
          rerr_q  <= 1'b0;
          rdata_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid   = rv_q;
  assign resp_err     = rerr_q;
  assign resp_data    = rdata_q;
  assign phy_md_addr  = md_q;
  assign phy_reg_addr = reg_q;
  assign phy_wr_data  = wd_q;
  assign phy_reg_rd   = rd_stb_q;
  assign phy_reg_wr   = wr_stb_q;

endmodule

// File: tb/tb_mdio_request_arbiter.sv
// tb_mdio_request_arbiter: directed bench with a timeline model of the
// arbiter and a simple busy-counting transceiver stand-in.
module tb_mdio_request_arbiter;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int TO = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_write;
  logic [5*N-1:0]  req_md_addr;
  logic [5*N-1:0]  req_reg_addr;
  logic [16*N-1:0] req_wr_data;
  logic [N-1:0]  resp_valid;
  logic          resp_err;
  logic [15:0]   resp_data;
  logic [4:0]    phy_md_addr;
  logic [4:0]    phy_reg_addr;
  logic [15:0]   phy_wr_data;
  logic          phy_reg_rd;
  logic          phy_reg_wr;
  logic          mgmt_busy = 1'b0;
  logic [15:0]   phy_rd_data = 16'hDEAD;

  mdio_request_arbiter #(.NUM_REQ(N), .SETTLE(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_md_addr(req_md_addr),
    .req_reg_addr(req_reg_addr), .req_wr_data(req_wr_data),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_data(resp_data), .phy_md_addr(phy_md_addr),
    .phy_reg_addr(phy_reg_addr), .phy_wr_data(phy_wr_data),
    .phy_reg_rd(phy_reg_rd), .phy_reg_wr(phy_reg_wr),
    .mgmt_busy(mgmt_busy), .phy_rd_data(phy_rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // transceiver stand-in
  int          xfer_len   = 3;
  logic [15:0] xfer_data  = 16'h0;
  logic        force_busy = 1'b0;
  int          busy_left  = 0;

  always @(posedge clk) begin
    #2;
    if (phy_reg_rd || phy_reg_wr) begin
      busy_left   = xfer_len;
      phy_rd_data = 16'hDEAD;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) phy_rd_data = xfer_data;
    end
    mgmt_busy = force_busy || (busy_left > 0);
  end

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int first_one(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // timeline model state
  bit          m_idle     = 1'b1;
  int          m_ptr      = N - 1;
  int          m_idx      = 0;
  bit          m_wr       = 1'b0;
  logic [4:0]  m_md       = '0;
  logic [4:0]  m_rg       = '0;
  logic [15:0] m_wd       = '0;
  int          m_issue_at = -1;
  int          m_wait_at  = -1;
  int          m_resp_at  = -1;
  bit          m_err      = 1'b0;
  logic [15:0] m_rdata    = '0;

  // observation log used by the literal checks
  int          acc_n   = 0;
  int          acc_q[$];
  int          acc_cyc = 0;
  int          resp_n  = 0;
  logic [N-1:0] r_rv   = '0;
  logic        r_err   = 1'b0;
  logic [15:0] r_data  = '0;
  int          r_cyc   = 0;
  int          iss_cyc = 0;
  int          rd_cnt  = 0;
  int          wr_cnt  = 0;
  logic [4:0]  iss_md  = '0;
  logic [4:0]  iss_rg  = '0;
  logic [15:0] iss_wd  = '0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [N-1:0] erv;
    int g;
    er = '0;
    g  = -1;
    if (m_idle && !mgmt_busy && (req_valid != '0)) begin
      g  = rr_pick(m_ptr, req_valid);
      er = N'(1 << g);
    end
    erv = (cyc == m_resp_at) ? N'(1 << m_idx) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("phy_reg_rd", 32'(phy_reg_rd),
        32'((cyc == m_issue_at) && !m_wr));
    chk("phy_reg_wr", 32'(phy_reg_wr),
        32'((cyc == m_issue_at) && m_wr));
    chk("phy_md_addr", 32'(phy_md_addr), 32'(m_md));
    chk("phy_reg_addr", 32'(phy_reg_addr), 32'(m_rg));
    chk("phy_wr_data", 32'(phy_wr_data), 32'(m_wd));
    chk("resp_valid", 32'(resp_valid), 32'(erv));
    if (erv != '0) begin
      chk("resp_err", 32'(resp_err), 32'(m_err));
      chk("resp_data", 32'(resp_data), 32'(m_rdata));
    end

    if ((req_valid & req_ready) != '0) begin
      acc_n++;
      acc_q.push_back(first_one(req_valid & req_ready));
      acc_cyc = cyc;
    end
    if (phy_reg_rd || phy_reg_wr) begin
      iss_cyc = cyc;
      iss_md  = phy_md_addr;
      iss_rg  = phy_reg_addr;
      iss_wd  = phy_wr_data;
      if (phy_reg_rd) rd_cnt++;
      if (phy_reg_wr) wr_cnt++;
    end
    if (resp_valid != '0) begin
      resp_n++;
      r_rv   = resp_valid;
      r_err  = resp_err;
      r_data = resp_data;
      r_cyc  = cyc;
    end

    if (rst) begin
      m_idle     = 1'b1;
      m_ptr      = N - 1;
      m_idx      = 0;
      m_wr       = 1'b0;
      m_md       = '0;
      m_rg       = '0;
      m_wd       = '0;
      m_issue_at = -1;
      m_wait_at  = -1;
      m_resp_at  = -1;
    end else if (g >= 0) begin
      m_idle     = 1'b0;
      m_ptr      = g;
      m_idx      = g;
      m_wr       = req_write[g];
      m_md       = 5'(req_md_addr >> (5 * g));
      m_rg       = 5'(req_reg_addr >> (5 * g));
      m_wd       = 16'(req_wr_data >> (16 * g));
      m_issue_at = cyc + 1;
      m_wait_at  = cyc + 2 + S;
      m_resp_at  = -1;
    end else if (!m_idle) begin
      if (cyc == m_resp_at) begin
        m_idle = 1'b1;
      end else if (m_resp_at < 0 && cyc >= m_wait_at) begin
        if (!mgmt_busy) begin
          m_resp_at = cyc + 1;
          m_err     = 1'b0;
          m_rdata   = m_wr ? 16'h0 : phy_rd_data;
        end else if (cyc - m_wait_at + 1 == TO) begin
          m_resp_at = cyc + 1;
          m_err     = 1'b1;
          m_rdata   = 16'h0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int tgt);
    int k;
    k = 0;
    while (acc_n < tgt && k < 400) begin
      step(1);
      k++;
    end
    chk("accept_wait", 32'(acc_n >= tgt), 32'd1);
  endtask

  task automatic wait_resp(input int tgt);
    int k;
    k = 0;
    while (resp_n < tgt && k < 400) begin
      step(1);
      k++;
    end
    chk("resp_wait", 32'(resp_n >= tgt), 32'd1);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [4:0] md,
                         input logic [4:0] rg, input logic [15:0] wd);
    req_write[i]          = wr;
    req_md_addr[5*i +: 5]  = md;
    req_reg_addr[5*i +: 5] = rg;
    req_wr_data[16*i +: 16] = wd;
  endtask

  initial begin
    int b;
    int rb;
    int r0;
    int w0;
    int rel;
    rst          = 1'b1;
    req_valid    = '0;
    req_write    = '0;
    req_md_addr  = '0;
    req_reg_addr = '0;
    req_wr_data  = '0;
    step(3);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_md", 32'(phy_md_addr), 32'd0);
    chk("rst_strobe", 32'(phy_reg_rd | phy_reg_wr), 32'd0);
    rst = 1'b0;
    step(1);

    // round robin with everyone requesting continuously
    for (int i = 0; i < N; i++)
      set_req(i, i[0], 5'(4 + i), 5'(8 + i), 16'(16'h1000 + i));
    xfer_len  = 3;
    xfer_data = 16'h1234;
    b  = acc_n;
    rb = resp_n;
    req_valid = '1;
    wait_acc(b + 8);
    req_valid = '0;
    wait_resp(rb + 8);
    for (int k = 0; k < 8; k++)
      if (acc_q.size() > b + k)
        chk($sformatf("rr_order%0d", k), 32'(acc_q[b+k]), 32'(k % 4));

    // single read, 40 busy cycles
    set_req(1, 1'b0, 5'd3, 5'd2, 16'hFFFF);
    xfer_len  = 40;
    xfer_data = 16'h796D;
    r0 = rd_cnt;
    w0 = wr_cnt;
    req_valid = 4'b0010;
    wait_acc(acc_n + 1);
    req_valid = '0;
    set_req(1, 1'b1, 5'd31, 5'd31, 16'h5555);
    wait_resp(resp_n + 1);
    chk("rd_rv", 32'(r_rv), 32'h2);
    chk("rd_data", 32'(r_data), 32'h796D);
    chk("rd_err", 32'(r_err), 32'd0);
    chk("rd_strobes", 32'(rd_cnt - r0), 32'd1);
    chk("rd_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("rd_md_reg", {22'd0, iss_md, iss_rg}, {22'd0, 5'd3, 5'd2});
    chk("rd_latency", 32'(r_cyc - iss_cyc), 32'd41);

    // single write
    set_req(0, 1'b1, 5'd1, 5'd0, 16'h8000);
    xfer_len = 5;
    r0 = rd_cnt;
    w0 = wr_cnt;
    req_valid = 4'b0001;
    wait_acc(acc_n + 1);
    req_valid = '0;
    wait_resp(resp_n + 1);
    chk("wr_rv", 32'(r_rv), 32'h1);
    chk("wr_data", 32'(r_data), 32'h0);
    chk("wr_strobes", 32'(wr_cnt - w0), 32'd1);
    chk("wr_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("wr_bus", 32'(iss_wd), 32'h8000);

    // busy before request blocks the grant
    force_busy = 1'b1;
    step(1);
    set_req(2, 1'b0, 5'd7, 5'd7, 16'h0);
    xfer_len  = 4;
    xfer_data = 16'h0BEE;
    req_valid = 4'b0100;
    b = acc_n;
    step(5);
    chk("busy_hold", 32'(acc_n), 32'(b));
    force_busy = 1'b0;
    rel = cyc;
    wait_acc(b + 1);
    chk("busy_grant_cyc", 32'(acc_cyc), 32'(rel));
    req_valid = '0;
    wait_resp(resp_n + 1);
    chk("busy_rd_data", 32'(r_data), 32'h0BEE);

    // busy stuck high: watchdog
    set_req(3, 1'b0, 5'd9, 5'd9, 16'h0);
    xfer_len = 0;
    req_valid = 4'b1000;
    wait_acc(acc_n + 1);
    req_valid = '0;
    force_busy = 1'b1;
    wait_resp(resp_n + 1);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_data", 32'(r_data), 32'd0);
    chk("to_rv", 32'(r_rv), 32'h8);
    chk("to_latency", 32'(r_cyc - iss_cyc), 32'd51);
    force_busy = 1'b0;
    step(2);

    // reset while waiting on the transceiver
    set_req(2, 1'b0, 5'd5, 5'd6, 16'h0);
    req_valid = 4'b0100;
    wait_acc(acc_n + 1);
    req_valid = '0;
    force_busy = 1'b1;
    step(8);
    rb = resp_n;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    force_busy = 1'b0;
    step(10);
    chk("rst_no_resp", 32'(resp_n), 32'(rb));
    chk("rst_md_zero", 32'(phy_md_addr), 32'd0);
    chk("rst_reg_zero", 32'(phy_reg_addr), 32'd0);
    set_req(0, 1'b0, 5'd1, 5'd1, 16'h0);
    set_req(2, 1'b0, 5'd2, 5'd2, 16'h0);
    xfer_len  = 2;
    xfer_data = 16'hA5A5;
    b = acc_n;
    req_valid = 4'b0101;
    wait_acc(b + 1);
    if (acc_q.size() > b)
      chk("post_rst_first", 32'(acc_q[b]), 32'd0);
    req_valid = 4'b0100;
    wait_resp(resp_n + 1);
    wait_acc(b + 2);
    req_valid = '0;
    wait_resp(resp_n + 1);
    if (acc_q.size() > b + 1)
      chk("post_rst_second", 32'(acc_q[b+1]), 32'd2);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
